// File: rtl/i_vec_pkg.sv
// Shared types and defaults for the I-vector fetch block and its lane multiplexer.
package i_vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } fetch_state_t;

  localparam int DEF_IDX_W         = 10;
  localparam int DEF_VAL_W         = 16;
  localparam int DEF_VALS_PER_LINE = 4;

  // Lane-select width; VALS_PER_LINE is a power of two, so this is exact.
  function automatic int lane_w(input int vals_per_line);
    return $clog2(vals_per_line);
  endfunction

endpackage

// File: rtl/i_line_lane_mux.sv
// Combinational selection of one I value from a packed SRAM line (lane 0 in the LSBs).
module i_line_lane_mux import i_vec_pkg::*; #(
  parameter int VALS_PER_LINE = DEF_VALS_PER_LINE,
  parameter int VAL_W         = DEF_VAL_W,
  localparam int LANE_W       = lane_w(VALS_PER_LINE)
) (
  input  logic [VALS_PER_LINE*VAL_W-1:0] line,
  input  logic [LANE_W-1:0]              lane,
  output logic [VAL_W-1:0]               value
);

  logic [VAL_W-1:0] lanes [VALS_PER_LINE];

  for (genvar k = 0; k < VALS_PER_LINE; k++) begin : g_unpack
    assign lanes[k] = line[k*VAL_W +: VAL_W];
  end

  // Lane index always covers the array exactly, so no out-of-range case exists.
  always_comb begin
    value = lanes[lane];
  end

endmodule

// File: rtl/i_vector_fetch.sv
// Column-indexed I-vector fetch with a single-line cache in front of the I-vector SRAM.
// Optional hit/miss statistics counters are built when I_FETCH_STATS_EN is defined.
module i_vector_fetch import i_vec_pkg::*; #(
  parameter int IDX_W         = DEF_IDX_W,
  parameter int VALS_PER_LINE = DEF_VALS_PER_LINE,
  parameter int VAL_W         = DEF_VAL_W,
  parameter int SRAM_LAT      = 1,
  localparam int LANE_W       = lane_w(VALS_PER_LINE),
  localparam int TAG_W        = IDX_W - LANE_W,
  localparam int LINE_W       = VALS_PER_LINE * VAL_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_col,
  input  logic              flush,
  output logic              sram_rd_en,
  output logic [TAG_W-1:0]  sram_addr,
  input  logic [LINE_W-1:0] sram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VAL_W-1:0]  out_value,
  output logic [IDX_W-1:0]  out_col
`ifdef I_FETCH_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam logic [2:0] LAST_WAIT = 3'(SRAM_LAT - 1);

  fetch_state_t      state;
  logic [IDX_W-1:0]  col;
  logic [2:0]        wait_cnt;
  logic              drop;
  logic [LINE_W-1:0] line;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;

  logic              accept;
  logic              hit;
  logic              fill;
  logic [LINE_W-1:0] mux_line;
  logic [LANE_W-1:0] mux_lane;
  logic [VAL_W-1:0]  mux_value;

  assign accept = req_valid && req_ready;
  assign hit    = line_valid && (req_col[IDX_W-1:LANE_W] == tag) && !flush;
  assign fill   = (state == WAIT) && (wait_cnt == LAST_WAIT);

  // One mux serves both paths: SRAM data while waiting, cached line otherwise.
  always_comb begin
    if (state == WAIT) begin
      mux_line = sram_rd_data;
      mux_lane = col[LANE_W-1:0];
    end else begin
      mux_line = line;
      mux_lane = req_col[LANE_W-1:0];
    end
  end

  i_line_lane_mux #(
    .VALS_PER_LINE (VALS_PER_LINE),
    .VAL_W         (VAL_W)
  ) u_lane_mux (
    .line  (mux_line),
    .lane  (mux_lane),
    .value (mux_value)
  );

  // Request/response FSM with registered handshake and SRAM strobe outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_addr  <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_col    <= '0;
      col        <= '0;
      wait_cnt   <= 3'd0;
      drop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            col       <= req_col;
            drop      <= 1'b0;
            if (hit) begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_value <= mux_value;
              out_col   <= req_col;
            end else begin
              state      <= ISSUE;
              sram_rd_en <= 1'b1;
              sram_addr  <= req_col[IDX_W-1:LANE_W];
            end
          end
        end
        ISSUE: begin
          sram_rd_en <= 1'b0;
          wait_cnt   <= 3'd0;
          state      <= WAIT;
          if (flush) drop <= 1'b1;
        end
        WAIT: begin
          if (flush) drop <= 1'b1;
          if (fill) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_value <= mux_value;
            out_col   <= col;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b0;
          sram_rd_en <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Line cache: a fill flushed while in flight is delivered but left invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line       <= '0;
      tag        <= '0;
      line_valid <= 1'b0;
    end else if (fill) begin
      line       <= sram_rd_data;
      tag        <= col[IDX_W-1:LANE_W];
      line_valid <= !(drop || flush);
    end else if (flush) begin
      line_valid <= 1'b0;
    end
  end

`ifdef I_FETCH_STATS_EN
  // Saturating hit/miss counters; flush clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (flush) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (accept) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'h0001;
      end else if (miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_vector_fetch.sv
// Directed bench for i_vector_fetch: default instance (SRAM_LAT=1) and a SRAM_LAT=3 instance.
module tb_i_vector_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_ready, flush = 1'b0;
  logic [9:0]  req_col = 10'h000;
  logic        sram_rd_en;
  logic [7:0]  sram_addr;
  logic [63:0] sram_rd_data;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_value;
  logic [9:0]  out_col;

  logic        req_valid3 = 1'b0, req_ready3, flush3 = 1'b0;
  logic [9:0]  req_col3 = 10'h000;
  logic        sram_rd_en3;
  logic [7:0]  sram_addr3;
  logic [63:0] sram_rd_data3;
  logic        out_valid3, out_ready3 = 1'b1;
  logic [15:0] out_value3;
  logic [9:0]  out_col3;

`ifdef I_FETCH_STATS_EN
  logic [15:0] hit_count, miss_count, hit_count3, miss_count3;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int xfer_cnt = 0;
  int snap;

  always #5 clock = ~clock;

  i_vector_fetch dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .flush(flush), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .sram_rd_data(sram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_col(out_col)
`ifdef I_FETCH_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  i_vector_fetch #(.SRAM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_col(req_col3), .flush(flush3), .sram_rd_en(sram_rd_en3), .sram_addr(sram_addr3),
    .sram_rd_data(sram_rd_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_value(out_value3), .out_col(out_col3)
`ifdef I_FETCH_STATS_EN
    , .hit_count(hit_count3), .miss_count(miss_count3)
`endif
  );

  // SRAM contents: line 3 is the test-plan line, others encode {addr, lane}.
  function automatic logic [63:0] line_of(input logic [7:0] a);
    if (a == 8'h03) return {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    return {a, 8'h03, a, 8'h02, a, 8'h01, a, 8'h00};
  endfunction

  // SRAM models: data is only valid in the cycle SRAM_LAT cycles after the strobe.
  logic       v1;
  logic [7:0] a1;
  logic [2:0] v3;
  logic [7:0] a3 [3];
  always @(posedge clock) begin
    v1    <= sram_rd_en;
    a1    <= sram_addr;
    v3    <= {v3[1:0], sram_rd_en3};
    a3[0] <= sram_addr3;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
    if (sram_rd_en) rd_cnt <= rd_cnt + 1;
    if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
  end
  assign sram_rd_data  = (v1 === 1'b1)    ? line_of(a1)    : {4{16'hBAD0}};
  assign sram_rd_data3 = (v3[2] === 1'b1) ? line_of(a3[2]) : {4{16'hBAD0}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_rd_en", 64'(sram_rd_en), 64'h0);
    check("rst_addr", 64'(sram_addr), 64'h0);
    check("rst_value", 64'(out_value), 64'h0);
    check("rst_col", 64'(out_col), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", 64'(req_ready), 64'h1);

    // Miss on col 0x00D
    req_valid = 1'b1; req_col = 10'h00D;
    @(negedge clock);
    req_valid = 1'b0;
    check("miss_rd_en", 64'(sram_rd_en), 64'h1);
    check("miss_addr", 64'(sram_addr), 64'h03);
    check("miss_ov_t1", 64'(out_valid), 64'h0);
    @(negedge clock);
    check("miss_ov_t2", 64'(out_valid), 64'h0);
    check("miss_rd_en_t2", 64'(sram_rd_en), 64'h0);
    @(negedge clock);
    check("miss_ov_t3", 64'(out_valid), 64'h1);
    check("miss_value", 64'(out_value), 64'h2222);
    check("miss_col", 64'(out_col), 64'h00D);
    @(negedge clock);
    check("miss_done_ov", 64'(out_valid), 64'h0);
    check("miss_done_ready", 64'(req_ready), 64'h1);

    // Hit on col 0x00F
    snap = rd_cnt;
    req_valid = 1'b1; req_col = 10'h00F;
    @(negedge clock);
    req_valid = 1'b0;
    check("hit_ov_t1", 64'(out_valid), 64'h1);
    check("hit_value", 64'(out_value), 64'h4444);
    check("hit_col", 64'(out_col), 64'h00F);
    check("hit_rd_en", 64'(sram_rd_en), 64'h0);
    @(negedge clock);
    check("hit_done_ov", 64'(out_valid), 64'h0);
    check("hit_no_read", 64'(rd_cnt - snap), 64'h0);
`ifdef I_FETCH_STATS_EN
    check("stats_hit", 64'(hit_count), 64'h1);
    check("stats_miss", 64'(miss_count), 64'h1);
`endif
    @(negedge clock);

    // Backpressure on a hit to col 0x00E
    out_ready = 1'b0;
    req_valid = 1'b1; req_col = 10'h00E;
    @(negedge clock);
    req_valid = 1'b0;
    snap = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", 64'(out_valid), 64'h1);
      check("bp_value", 64'(out_value), 64'h3333);
      check("bp_col", 64'(out_col), 64'h00E);
      check("bp_req_ready", 64'(req_ready), 64'h0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_done_ov", 64'(out_valid), 64'h0);
    @(negedge clock);
    check("bp_one_xfer", 64'(xfer_cnt - snap), 64'h1);
    check("bp_ready_back", 64'(req_ready), 64'h1);

    // Flush on accept edge forces a miss; flush during WAIT leaves the line invalid
    req_valid = 1'b1; req_col = 10'h00C; flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_acc_rd_en", 64'(sram_rd_en), 64'h1);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_wait_ov", 64'(out_valid), 64'h1);
    check("flush_wait_value", 64'(out_value), 64'h1111);
    @(negedge clock);
    req_valid = 1'b1; req_col = 10'h00D;
    @(negedge clock);
    req_valid = 1'b0;
    check("flush_refetch_rd_en", 64'(sram_rd_en), 64'h1);
    check("flush_refetch_ov", 64'(out_valid), 64'h0);
    @(negedge clock);
    @(negedge clock);
    check("flush_refetch_value", 64'(out_value), 64'h2222);
    @(negedge clock);

    // Reset while in WAIT discards the result and invalidates line 3
    req_valid = 1'b1; req_col = 10'h010;
    @(negedge clock);
    req_valid = 1'b0;
    check("rw_rd_en", 64'(sram_rd_en), 64'h1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rw_ov_async", 64'(out_valid), 64'h0);
    check("rw_ready_async", 64'(req_ready), 64'h0);
    @(negedge clock);
    check("rw_ov_held", 64'(out_valid), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    check("rw_req_ready", 64'(req_ready), 64'h1);
    check("rw_ov_after", 64'(out_valid), 64'h0);
    req_valid = 1'b1; req_col = 10'h00C;
    @(negedge clock);
    req_valid = 1'b0;
    check("rw_next_miss", 64'(sram_rd_en), 64'h1);
    @(negedge clock);
    @(negedge clock);
    check("rw_next_value", 64'(out_value), 64'h1111);
    @(negedge clock);

    // Boundary col 0x3FF on the SRAM_LAT=3 instance
    req_valid3 = 1'b1; req_col3 = 10'h3FF;
    @(negedge clock);
    req_valid3 = 1'b0;
    check("bnd_rd_en", 64'(sram_rd_en3), 64'h1);
    check("bnd_addr", 64'(sram_addr3), 64'hFF);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clock);
      check("bnd_ov_early", 64'(out_valid3), 64'h0);
    end
    @(negedge clock);
    check("bnd_ov_t5", 64'(out_valid3), 64'h1);
    check("bnd_value", 64'(out_value3), 64'hFF03);
    check("bnd_col", 64'(out_col3), 64'h3FF);
    @(negedge clock);
    check("bnd_done_ov", 64'(out_valid3), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
